// File: rtl/mul_unit_pkg.sv
// Shared encodings for the multiply/divide unit: mul_op codes, FSM states, operand sign rules.
// XLEN defaults to 32 unless the build defines the XLEN macro.
`ifndef XLEN
`define XLEN 32
`endif

package mul_unit_pkg;

    localparam int XLEN_DEFAULT = `XLEN;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DONE    = 2'b10
    } mul_state_e;

    function automatic logic mcand_is_signed(input mul_op_e op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic mplier_is_signed(input mul_op_e op);
        return (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/mul_unit_if.sv
// start/busy/ready handshake bundle between EX-stage control (master) and mul_unit (slave).
interface mul_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      mul_op;
    logic            is_word_op;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            ready;

    modport master (
        output start, mul_op, is_word_op, multiplicand, multiplier,
        input  result, busy, ready
    );

    modport slave (
        input  start, mul_op, is_word_op, multiplicand, multiplier,
        output result, busy, ready
    );
endinterface

// File: rtl/mul_operand_cond.sv
// Conditions one multiply operand: W-bit magnitude, sign (when treated as signed) and zero flag.
// word_sel selects the 32-bit MULW view of a 64-bit operand.
module mul_operand_cond #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] operand,
    input  logic            is_signed,
    input  logic            word_sel,
    output logic [XLEN-1:0] mag,
    output logic            neg,
    output logic            zero
);

    logic [31:0] low_word;

    assign low_word = operand[31:0];

    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag  = '0;
        neg  = 1'b0;
        zero = 1'b0;
        if (word_sel) begin
            neg       = is_signed & low_word[31];
            mag[31:0] = neg ? (32'd0 - low_word) : low_word;
            zero      = (low_word == 32'd0);
        end else begin
            neg  = is_signed & operand[XLEN-1];
            mag  = neg ? (-operand) : operand;
            zero = (operand == '0);
        end
    end

endmodule

// File: rtl/mul_unit.sv
// mul_unit: one-bit-per-cycle shift-add multiplier for MUL/MULH/MULHSU/MULHU and RV64 MULW.
// Define MUL_EARLY_OUT_EN to finish requests with a zero operand in one cycle.
//
// state      | meaning
// IDLE       | waiting for start; operands captured on accept
// COMPUTE    | one multiplier bit consumed per cycle
// DONE       | sign fixup, result slice registered, ready pulsed
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic       clk,
    input logic       reset_n,
    mul_unit_if.slave bus
);

`ifdef MUL_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam logic [6:0] N_FULL = 7'(XLEN);
    localparam logic [6:0] N_WORD = 7'd32;

    mul_state_e        state;
    mul_state_e        state_next;
    mul_op_e           op_in;
    mul_op_e           op_reg;
    logic              word_sel;
    logic              word_reg;
    logic              mcand_sgn;
    logic              mplier_sgn;
    logic [XLEN-1:0]   mcand_mag;
    logic [XLEN-1:0]   mplier_mag;
    logic              mcand_neg;
    logic              mplier_neg;
    logic              mcand_zero;
    logic              mplier_zero;
    logic              early_out;
    logic [XLEN-1:0]   mcand_reg;
    logic [XLEN-1:0]   mplier_reg;
    logic              neg_reg;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     sum_hi;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod;
    logic [6:0]        count;
    logic [6:0]        n_target;
    logic [XLEN-1:0]   result_next;
    logic [XLEN-1:0]   result_reg;
    logic              ready_reg;

    assign op_in      = mul_op_e'(bus.mul_op);
    assign word_sel   = (XLEN == 64) && bus.is_word_op;
    assign mcand_sgn  = mcand_is_signed(op_in);
    assign mplier_sgn = mplier_is_signed(op_in);

    mul_operand_cond #(.XLEN(XLEN)) u_mcand_cond (
        .operand   (bus.multiplicand),
        .is_signed (mcand_sgn),
        .word_sel  (word_sel),
        .mag       (mcand_mag),
        .neg       (mcand_neg),
        .zero      (mcand_zero)
    );

    mul_operand_cond #(.XLEN(XLEN)) u_mplier_cond (
        .operand   (bus.multiplier),
        .is_signed (mplier_sgn),
        .word_sel  (word_sel),
        .mag       (mplier_mag),
        .neg       (mplier_neg),
        .zero      (mplier_zero)
    );

    assign early_out = EARLY_OUT && (mcand_zero || mplier_zero);
    assign n_target  = word_reg ? N_WORD : N_FULL;

    assign sum_hi   = {1'b0, acc[2*XLEN-1:XLEN]} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
    assign acc_step = {sum_hi, acc[XLEN-1:1]};

    // A 32-step word multiply leaves its product XLEN-32 bits above the LSB of acc.
    assign prod_mag = word_reg ? (acc >> (XLEN - 32)) : acc;
    assign prod     = neg_reg ? (-prod_mag) : prod_mag;

    always_comb begin
        result_next = '0;
        if (word_reg) begin
            result_next       = {XLEN{prod[31]}};
            result_next[31:0] = prod[31:0];
        end else if (op_reg == MUL_OP_MUL) begin
            result_next = prod[XLEN-1:0];
        end else begin
            result_next = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = early_out ? ST_DONE : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if ((count + 7'd1) == n_target) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_reg     <= MUL_OP_MUL;
            word_reg   <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            acc        <= '0;
            count      <= '0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_reg <= 1'b0;
                    if (bus.start) begin
                        op_reg     <= op_in;
                        word_reg   <= word_sel;
                        mcand_reg  <= mcand_mag;
                        mplier_reg <= mplier_mag;
                        neg_reg    <= mcand_neg ^ mplier_neg;
                        acc        <= '0;
                        count      <= '0;
                    end
                end
                ST_COMPUTE: begin
                    acc        <= acc_step;
                    mplier_reg <= mplier_reg >> 1;
                    count      <= count + 7'd1;
                end
                ST_DONE: begin
                    result_reg <= result_next;
                    ready_reg  <= 1'b1;
                end
                default: begin
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.result = result_reg;
    assign bus.ready  = ready_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: an XLEN=32 and an XLEN=64 instance driven through mul_unit_if.
module tb_mul_unit;
    import mul_unit_pkg::*;

`ifdef MUL_EARLY_OUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    mul_unit_if #(.XLEN(32)) if32 ();
    mul_unit_if #(.XLEN(64)) if64 ();

    mul_unit #(.XLEN(32)) u_dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
    mul_unit #(.XLEN(64)) u_dut64 (.clk(clk), .reset_n(reset_n), .bus(if64));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle; returns #1 after the edge that samples start, with operands scrambled.
    task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if32.start        = 1'b1;
        if32.mul_op       = op;
        if32.is_word_op   = 1'b0;
        if32.multiplicand = a;
        if32.multiplier   = b;
        @(posedge clk);
        #1;
        if32.start        = 1'b0;
        if32.mul_op       = ~op;
        if32.multiplicand = 32'hDEAD_BEEF;
        if32.multiplier   = 32'h1234_5678;
    endtask

    task automatic wait32(input string tag, input logic [31:0] exp, input int exp_lat, input bit chained);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        while (!if32.ready && lat < 200) begin
            if (if32.busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(if32.result), 64'(exp));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
        if (!chained) begin
            @(posedge clk);
            #1;
            check({tag, " ready pulse width"}, 64'(if32.ready), 64'd0);
        end
    endtask

    task automatic start64(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        if64.start        = 1'b1;
        if64.mul_op       = op;
        if64.is_word_op   = word;
        if64.multiplicand = a;
        if64.multiplier   = b;
        @(posedge clk);
        #1;
        if64.start        = 1'b0;
        if64.is_word_op   = ~word;
        if64.multiplicand = 64'hDEAD_BEEF_CAFE_F00D;
        if64.multiplier   = 64'h0123_4567_89AB_CDEF;
    endtask

    task automatic wait64(input string tag, input logic [63:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        while (!if64.ready && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, if64.result, exp);
        @(posedge clk);
        #1;
        check({tag, " ready pulse width"}, 64'(if64.ready), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pulses;
        logic [31:0] got;

        if32.start = 1'b0; if32.mul_op = 2'b00; if32.is_word_op = 1'b0;
        if32.multiplicand = '0; if32.multiplier = '0;
        if64.start = 1'b0; if64.mul_op = 2'b00; if64.is_word_op = 1'b0;
        if64.multiplicand = '0; if64.multiplier = '0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result32", 64'(if32.result), 64'd0);
        check("reset ready32", 64'(if32.ready), 64'd0);
        check("reset busy32", 64'(if32.busy), 64'd0);
        check("reset result64", if64.result, 64'd0);
        check("reset busy64", 64'(if64.busy), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        start32(MUL_OP_MUL, 32'd7, 32'd6);
        wait32("mul 7*6", 32'h0000_002A, 33, 1'b0);
        start32(MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000);
        wait32("mulh minneg^2", 32'h4000_0000, 33, 1'b0);
        start32(MUL_OP_MUL, 32'h8000_0000, 32'h8000_0000);
        wait32("mul minneg^2", 32'h0000_0000, 33, 1'b0);
        start32(MUL_OP_MULH, 32'hFFFF_FFFD, 32'd5);
        wait32("mulh -3*5", 32'hFFFF_FFFF, 33, 1'b0);
        start32(MUL_OP_MUL, 32'hFFFF_FFFD, 32'd5);
        wait32("mul -3*5", 32'hFFFF_FFF1, 33, 1'b0);
        start32(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32("mulhsu -1*max", 32'hFFFF_FFFF, 33, 1'b0);
        start32(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32("mulhu max*max", 32'hFFFF_FFFE, 33, 1'b0);
        start32(MUL_OP_MULHSU, 32'd5, 32'hFFFF_FFFF);
        wait32("mulhsu 5*max", 32'h0000_0004, 33, 1'b0);
        start32(MUL_OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait32("mulh maxpos^2", 32'h3FFF_FFFF, 33, 1'b0);

        // Operands churn and start pulses while busy must not disturb the accepted request.
        start32(MUL_OP_MUL, 32'd3, 32'd4);
        pulses = 0;
        got    = 32'hFFFF_FFFF;
        for (int i = 0; i < 45; i++) begin
            if32.start        = (i < 30) ? i[0] : 1'b0;
            if32.multiplicand = $urandom;
            if32.multiplier   = $urandom;
            if32.mul_op       = 2'($urandom_range(3, 0));
            @(posedge clk);
            #1;
            if (if32.ready) begin
                pulses++;
                got = if32.result;
            end
        end
        if32.start = 1'b0;
        check("busy churn ready count", 64'(pulses), 64'd1);
        check("busy churn result", 64'(got), 64'd12);

        // Reset mid-operation aborts without a ready pulse.
        start32(MUL_OP_MUL, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 64'(if32.busy), 64'd0);
        check("abort ready", 64'(if32.ready), 64'd0);
        check("abort result", 64'(if32.result), 64'd0);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (if32.ready) pulses++;
        end
        check("abort no ready", 64'(pulses), 64'd0);

        // Zero operand, then back-to-back start on the ready cycle.
        start32(MUL_OP_MUL, 32'd0, 32'd123);
        wait32("mul 0*123", 32'd0, ZLAT, 1'b1);
        start32(MUL_OP_MUL, 32'd5, 32'd5);
        wait32("b2b mul 5*5", 32'd25, 33, 1'b0);
        start32(MUL_OP_MULH, 32'd0, 32'hFFFF_FFFB);
        wait32("mulh 0*-5", 32'd0, ZLAT, 1'b0);

        start64(MUL_OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2);
        wait64("mulw 7fffffff*2", 64'hFFFF_FFFF_FFFF_FFFE, 33);
        start64(MUL_OP_MULHU, 1'b1, 64'h1234_5678_0000_0003, 64'hFFFF_0000_0000_0005);
        wait64("mulw upper ignored", 64'h0000_0000_0000_000F, 33);
        start64(MUL_OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait64("mulhu64 max*2", 64'h0000_0000_0000_0001, 65);
        start64(MUL_OP_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
        wait64("mul64 -3*5", 64'hFFFF_FFFF_FFFF_FFF1, 65);
        start64(MUL_OP_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
        wait64("mulh64 -3*5", 64'hFFFF_FFFF_FFFF_FFFF, 65);
        start64(MUL_OP_MUL, 1'b1, 64'h0000_0001_0000_0000, 64'd7);
        wait64("mulw zero low word", 64'd0, ZLAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
